// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op at a time to the Arith/Logic/CMP/Shift units and returns the result
// Ports: clk/rst (async, active-low); cmd_* valid/ready command in; alu_fun/a/b and *_EN drive the units;
// *_out/*_flag are unit results; res_* valid/ready response out (data, producing unit, flag error).
module alu_op_sequencer #(
  parameter int WIDTH    = 16,
  parameter int UNIT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fun,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [3:0]       alu_fun,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             Arith_EN,
  output logic             Logic_EN,
  output logic             CMP_EN,
  output logic             Shift_EN,
  input  logic [WIDTH-1:0] Arith_out,
  input  logic [WIDTH-1:0] Logic_out,
  input  logic [WIDTH-1:0] CMP_out,
  input  logic [WIDTH-1:0] Shift_out,
  input  logic             Arith_flag,
  input  logic             Logic_flag,
  input  logic             CMP_flag,
  input  logic             Shift_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_unit,
  output logic             res_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] sel_out;
  logic             sel_flag;
  // the held alu_fun selects which unit is sampled, so other units' outputs never matter
  always_comb begin
    sel_out  = alu_fun[3] ? (alu_fun[2] ? Shift_out : CMP_out) : (alu_fun[2] ? Logic_out : Arith_out);
    sel_flag = alu_fun[3] ? (alu_fun[2] ? Shift_flag : CMP_flag) : (alu_fun[2] ? Logic_flag : Arith_flag);
  end
  assign cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                                 <= IDLE;
      cnt                                   <= '0;
      alu_fun                               <= '0;
      a                                     <= '0;
      b                                     <= '0;
      {Shift_EN, CMP_EN, Logic_EN, Arith_EN} <= '0;
      res_valid                             <= 1'b0;
      res_data                              <= '0;
      res_unit                              <= '0;
      res_err                               <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_fun                               <= cmd_fun;
          a                                     <= cmd_a;
          b                                     <= cmd_b;
          {Shift_EN, CMP_EN, Logic_EN, Arith_EN} <= 4'b0001 << cmd_fun[3:2];
          state                                 <= ISSUE;
        end
        ISSUE: begin
          {Shift_EN, CMP_EN, Logic_EN, Arith_EN} <= '0;
          cnt                                   <= 3'(UNIT_LAT - 1);
          state                                 <= WAIT;
        end
        WAIT: if (cnt == 3'd0) begin
          res_data  <= sel_out;
          res_err   <= ~sel_flag;
          res_unit  <= alu_fun[3:2];
          res_valid <= 1'b1;
          state     <= RESP;
        end else cnt <= cnt - 3'd1;
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven and random checks of the sequencer at UNIT_LAT=1 and UNIT_LAT=3
module tb_alu_op_sequencer;
  localparam int W = 16;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [1:0] cmd_valid, res_ready, cmd_ready, res_valid, res_err;
  logic [1:0][3:0] cmd_fun, alu_fun, en;
  logic [1:0][W-1:0] cmd_a, cmd_b, a, b, res_data;
  logic [1:0][1:0] res_unit;
  logic [1:0][3:0][W-1:0] uout;
  logic [1:0][3:0] uflag;
  logic ovr_en, flag_v;
  logic [W-1:0] ovr;
  int vec = 0, bad = 0;

  function automatic logic [W-1:0] unit_fn(logic [3:0] f, logic [W-1:0] x, logic [W-1:0] y);
    case (f)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x * y;
      4'h3: return x;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return x ^ y;
      4'h7: return ~x;
      4'h8: return W'(x == y);
      4'h9: return W'(x > y);
      4'hA: return W'(x < y);
      4'hB: return W'(x != y);
      4'hC: return x << y[3:0];
      4'hD: return x >> y[3:0];
      4'hE: return W'($signed(x) >>> y[3:0]);
      default: return {x[W-2:0], x[W-1]};
    endcase
  endfunction

  alu_op_sequencer #(.WIDTH(W), .UNIT_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_fun(cmd_fun[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .alu_fun(alu_fun[0]), .a(a[0]), .b(b[0]),
    .Arith_EN(en[0][0]), .Logic_EN(en[0][1]), .CMP_EN(en[0][2]), .Shift_EN(en[0][3]),
    .Arith_out(uout[0][0]), .Logic_out(uout[0][1]), .CMP_out(uout[0][2]), .Shift_out(uout[0][3]),
    .Arith_flag(uflag[0][0]), .Logic_flag(uflag[0][1]), .CMP_flag(uflag[0][2]), .Shift_flag(uflag[0][3]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]), .res_unit(res_unit[0]),
    .res_err(res_err[0]));

  alu_op_sequencer #(.WIDTH(W), .UNIT_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_fun(cmd_fun[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .alu_fun(alu_fun[1]), .a(a[1]), .b(b[1]),
    .Arith_EN(en[1][0]), .Logic_EN(en[1][1]), .CMP_EN(en[1][2]), .Shift_EN(en[1][3]),
    .Arith_out(uout[1][0]), .Logic_out(uout[1][1]), .CMP_out(uout[1][2]), .Shift_out(uout[1][3]),
    .Arith_flag(uflag[1][0]), .Logic_flag(uflag[1][1]), .CMP_flag(uflag[1][2]), .Shift_flag(uflag[1][3]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]), .res_unit(res_unit[1]),
    .res_err(res_err[1]));

  // registered unit models: capture on their enable, hold otherwise
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      for (int u = 0; u < 4; u++)
        if (en[k][u]) begin
          uout[k][u]  <= ovr_en ? ovr : unit_fn(alu_fun[k], a[k], b[k]);
          uflag[k][u] <= flag_v;
        end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic run_op(int k, logic [3:0] f, logic [W-1:0] x, logic [W-1:0] y, logic oe, logic [W-1:0] ov,
                        logic fl, logic [W-1:0] ed, logic [1:0] eu, logic ee, int hold);
    int lat = k ? 3 : 1;
    int i;
    @(negedge clk);
    ovr_en = oe; ovr = ov; flag_v = fl;
    chk("cmd_ready_idle", cmd_ready[k], 1);
    cmd_valid[k] = 1; cmd_fun[k] = f; cmd_a[k] = x; cmd_b[k] = y; res_ready[k] = (hold == 0);
    @(negedge clk);
    cmd_fun[k] = ~f; cmd_a[k] = ~x; cmd_b[k] = ~y;
    i = 0;
    while (!res_valid[k] && i < 20) begin
      chk("enable", en[k], i == 0 ? 4'b0001 << f[3:2] : 4'b0000);
      chk("held", {alu_fun[k], a[k], b[k]}, {f, x, y});
      chk("cmd_ready_busy", cmd_ready[k], 0);
      @(negedge clk);
      i++;
    end
    cmd_valid[k] = 0;
    chk("latency", i, lat + 1);
    chk("res_data", res_data[k], ed);
    chk("res_unit", res_unit[k], eu);
    chk("res_err", res_err[k], ee);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", res_valid[k], 1);
      chk("bp_data", {res_data[k], res_unit[k], res_err[k]}, {ed, eu, ee});
      chk("bp_cmd_ready", cmd_ready[k], 0);
    end
    res_ready[k] = 1;
    @(negedge clk);
    chk("consumed", res_valid[k], 0);
    chk("cmd_ready_after", cmd_ready[k], 1);
    res_ready[k] = 0;
  endtask

  task automatic reset_mid(int k, int at);
    @(negedge clk);
    ovr_en = 0; flag_v = 1;
    cmd_valid[k] = 1; cmd_fun[k] = 4'b0100; cmd_a[k] = 16'h1234; cmd_b[k] = 16'h00FF; res_ready[k] = 1;
    @(negedge clk);
    cmd_valid[k] = 0;
    if (at == 0) chk("pre_reset_en", en[k], 4'b0010);
    repeat (at) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_en", en[k], 0);
    chk("rst_mid_valid", res_valid[k], 0);
    chk("rst_mid_ab", {a[k], b[k]}, 0);
    chk("rst_mid_idle", cmd_ready[k], 1);
    #2 rst = 1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", {res_valid[k], en[k], cmd_ready[k]}, 6'b000001);
    end
    res_ready[k] = 0;
  endtask

  typedef struct {
    int k; logic [3:0] f; logic [W-1:0] x, y; logic oe; logic [W-1:0] ov;
    logic fl; logic [W-1:0] ed; logic [1:0] eu; logic ee; int hold;
  } vec_t;
  vec_t tv[9];

  initial begin
    tv[0] = '{0, 4'b0100, 16'h00FF, 16'h0F0F, 0, 16'h0000, 1, 16'h000F, 2'b01, 0, 0};
    tv[1] = '{0, 4'b0000, 16'h1234, 16'h1111, 0, 16'h0000, 1, 16'h2345, 2'b00, 0, 5};
    tv[2] = '{0, 4'b0001, 16'h5555, 16'h0001, 1, 16'h1111, 1, 16'h1111, 2'b00, 0, 0};
    tv[3] = '{0, 4'b0110, 16'h5555, 16'h0001, 1, 16'h2222, 1, 16'h2222, 2'b01, 0, 1};
    tv[4] = '{0, 4'b1011, 16'h5555, 16'h0001, 1, 16'h3333, 1, 16'h3333, 2'b10, 0, 0};
    tv[5] = '{0, 4'b1110, 16'h5555, 16'h0001, 1, 16'h4444, 1, 16'h4444, 2'b11, 0, 2};
    tv[6] = '{0, 4'b1101, 16'h0F00, 16'h0004, 1, 16'hBEEF, 0, 16'hBEEF, 2'b11, 1, 0};
    tv[7] = '{1, 4'b0010, 16'h0003, 16'h0005, 0, 16'h0000, 1, 16'h000F, 2'b00, 0, 2};
    tv[8] = '{1, 4'b0110, 16'hAAAA, 16'hFFFF, 0, 16'h0000, 1, 16'h5555, 2'b01, 0, 0};
    cmd_valid = '0; res_ready = '0; cmd_fun = '0; cmd_a = '0; cmd_b = '0;
    ovr_en = 0; ovr = '0; flag_v = 1;
    #12;
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", {alu_fun[k], a[k], b[k], res_data[k], res_unit[k], en[k], res_valid[k], res_err[k]}, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 2'b11);
    foreach (tv[i])
      run_op(tv[i].k, tv[i].f, tv[i].x, tv[i].y, tv[i].oe, tv[i].ov, tv[i].fl, tv[i].ed, tv[i].eu, tv[i].ee, tv[i].hold);
    reset_mid(0, 0);
    reset_mid(1, 2);
    for (int n = 0; n < 40; n++) begin
      logic [3:0] f = 4'($urandom);
      logic [W-1:0] x = W'($urandom), y = W'($urandom);
      logic fl = 1'($urandom);
      run_op(n % 2, f, x, y, 0, 16'h0000, fl, unit_fn(f, x, y), f[3:2], ~fl, int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator/controller side of the ALU execution units. It accepts one operation at a time over a valid/ready command interface and decodes alu_fun[3:2] into a one-hot unit enable. It waits the fixed unit latency, then captures the selected unit's registered result and flag. It returns the result over a valid/ready response interface and sits between the system command path and the Arith/Logic/CMP/Shift units.

Parameters:
WIDTH, 16, operand and result width
UNIT_LAT, 1, cycles from the enable cycle's closing edge to the edge where the unit output is sampled (1..7)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_fun  input  4  ALU function code
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_fun  output  4  function code driven to the units
a  output  WIDTH  operand A driven to the units
b  output  WIDTH  operand B driven to the units
Arith_EN  output  1  arithmetic unit enable
Logic_EN  output  1  logic unit enable
CMP_EN  output  1  compare unit enable
Shift_EN  output  1  shift unit enable
Arith_out / Logic_out / CMP_out / Shift_out  input  WIDTH each  unit results
Arith_flag / Logic_flag / CMP_flag / Shift_flag  input  1 each  unit result-valid flags
res_valid  output  1  response present
res_ready  input  1  consumer accepts the response
res_data  output  WIDTH  captured result
res_unit  output  2  unit that produced the result (cmd_fun[3:2])
res_err  output  1  selected unit's flag was low at sample time

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, latency counter=0.
  - alu_fun, a, b, res_data, res_unit = 0.
  - All *_EN, res_valid and res_err = 0.
  - cmd_ready=1 once reset is released.
- Reset asserted mid-operation:
  - The in-flight command is dropped, no response is produced, and all enables drop immediately.
- All outputs are registered. cmd_ready is a decode of the state register: 1 only in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On cmd_valid&cmd_ready at edge E0: latch cmd_fun, cmd_a and cmd_b into alu_fun, a and b.
  - At the same edge, set the enable selected by cmd_fun[3:2]: 00 Arith, 01 Logic, 10 CMP, 11 Shift.
  - Go to ISSUE.
- ISSUE:
  - Exactly one enable is high for exactly one cycle (E0..E1).
  - At E1: clear the enable, load counter=UNIT_LAT-1, go to WAIT.
- WAIT:
  - alu_fun, a and b stay held.
  - When counter==0, at that edge (E1+UNIT_LAT):
    - res_data = selected unit's out.
    - res_err = ~selected unit's flag.
    - res_unit = alu_fun[3:2].
    - res_valid = 1; go to RESP.
  - Otherwise decrement the counter.
- Response timing: with UNIT_LAT=1, res_valid rises 2 cycles after command acceptance.
- RESP:
  - res_valid, res_data, res_unit and res_err are held stable until res_valid&res_ready.
  - At that edge: res_valid=0, go to IDLE.
  - No new command is accepted in the same cycle; throughput is at most 1 op per UNIT_LAT+3 cycles.
- Outputs of non-selected units are ignored. Only the selected unit's flag determines res_err.
- cmd_valid while not in IDLE is ignored; the command is not lost because cmd_ready=0.
- The consumer may hold res_ready high permanently; the response is then consumed at the first edge with res_valid=1.
- alu_fun[1:0] is passed through unmodified; only bits [3:2] are decoded.

Test Plan:
- Logic AND, UNIT_LAT=1: cmd_fun=4'b0100, a=16'h00FF, b=16'h0F0F, bench logic model registered → Logic_EN high exactly 1 cycle, others 0; res_valid 2 cycles after acceptance; res_data=16'h000F, res_unit=2'b01, res_err=0.
- Back-pressure: res_ready=0 for 5 cycles after res_valid → res_data is stable and cmd_ready=0 throughout; on res_ready=1, one response is consumed and cmd_ready=1 the next cycle.
- Unit decode sweep: cmd_fun[3:2]=00,01,10,11, each with a distinct unit result (16'h1111, 16'h2222, 16'h3333, 16'h4444) → the matching enable is one-hot, and res_data/res_unit match the selected unit only.
- Flag error: Shift model returns Shift_flag=0 with out=16'hBEEF for cmd_fun=4'b1101 → res_err=1, res_data=16'hBEEF, res_unit=2'b11.
- Latency: UNIT_LAT=3 → res_valid rises 4 cycles after acceptance; a and b stay held through WAIT.
- Async reset mid-operation: rst=0 during WAIT → enables and res_valid=0 immediately, state IDLE; after release cmd_ready=1 and no stale response appears.
